// File: rtl/counter_m10_monitor.sv
`default_nettype none
//==============================================================================
// Module      : counter_m10_monitor
// Description : Watches a mod-10 up/down counter (ones digit q, carry/borrow c,
//               direction d) and rebuilds a two-digit decimal value from it.
//               Each sample (en_i=1) is checked against the step implied by the
//               previous sample. A mismatch pulses err_o, bumps a saturating
//               error counter and drops lock until the next valid digit.
//
//               Optional feature (macro COUNTER_M10_MONITOR_SEG7_EN): registered
//               7-segment decodes of ones/tens, order {g,f,e,d,c,b,a}.
//
// Ports       : clk         - clock, rising edge
//               rst         - synchronous active-high reset
//               en_i        - sample strobe
//               d_i         - observed direction (0 up, 1 down)
//               q_i[3:0]    - observed ones digit
//               c_i         - observed carry/borrow
//               ones_o[3:0] - tracked ones digit
//               tens_o[3:0] - tracked tens digit (0..9)
//               locked_o    - high while tracking
//               err_o       - one-cycle pulse per violation
//               err_cnt_o   - saturating violation count
//               seg_ones_o, seg_tens_o [6:0] - only with the SEG7 macro
// Revision    : 1.0 - initial release
//==============================================================================
module counter_m10_monitor #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             d_i,
    input  logic [3:0]       q_i,
    input  logic             c_i,
    output logic [3:0]       ones_o,
    output logic [3:0]       tens_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
`ifdef COUNTER_M10_MONITOR_SEG7_EN
    ,
    output logic [6:0]       seg_ones_o,
    output logic [6:0]       seg_tens_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] C_ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic             dir_q, dir_d;       // direction in force for the next step
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             w_q_valid;
    logic [3:0]       w_exp_q;
    logic             w_c_exp;

    assign w_q_valid = (q_i <= 4'd9);
    // Next digit predicted from the previous sample and its direction.
    assign w_exp_q   = dir_q ? ((ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1)
                             : ((ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1);
    // Carry/borrow belongs to the sample itself, so it uses the current d.
    assign w_c_exp   = ((q_i == 4'd9) && !d_i) || ((q_i == 4'd0) && d_i);

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        if (en_i) begin
            case (state_q)
                ST_IDLE, ST_RESYNC: begin
                    // Re-acquire: take the digit as-is, no step check.
                    if (w_q_valid) begin
                        ones_d  = q_i;
                        dir_d   = d_i;
                        state_d = ST_TRACK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (!w_q_valid || (q_i != w_exp_q) || (c_i != w_c_exp)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESYNC;
                    end else begin
                        ones_d = q_i;
                        dir_d  = d_i;
                        // A checked step out of 9 (up) or 0 (down) is a digit wrap.
                        if (!dir_q && (ones_q == 4'd9)) begin
                            tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                        end else if (dir_q && (ones_q == 4'd0)) begin
                            tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        locked_d  = (state_d == ST_TRACK);
        err_cnt_d = (err_d && (err_cnt_q != C_ERR_MAX)) ? err_cnt_q + ERR_W'(1)
                                                        : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            dir_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            dir_q     <= dir_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ones_o    = ones_q;
    assign tens_o    = tens_q;
    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

`ifdef COUNTER_M10_MONITOR_SEG7_EN
    function automatic logic [6:0] f_seg7(input logic [3:0] v);
        case (v)
            4'd0:    f_seg7 = 7'b0111111;
            4'd1:    f_seg7 = 7'b0000110;
            4'd2:    f_seg7 = 7'b1011011;
            4'd3:    f_seg7 = 7'b1001111;
            4'd4:    f_seg7 = 7'b1100110;
            4'd5:    f_seg7 = 7'b1101101;
            4'd6:    f_seg7 = 7'b1111101;
            4'd7:    f_seg7 = 7'b0000111;
            4'd8:    f_seg7 = 7'b1111111;
            4'd9:    f_seg7 = 7'b1101111;
            default: f_seg7 = 7'b0000000;
        endcase
    endfunction

    logic [6:0] seg_ones_q, seg_tens_q;

    // Decoded from the next-state digits so segments change with ones/tens.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_ones_q <= 7'b0111111;
            seg_tens_q <= 7'b0111111;
        end else begin
            seg_ones_q <= f_seg7(ones_d);
            seg_tens_q <= f_seg7(tens_d);
        end
    end

    assign seg_ones_o = seg_ones_q;
    assign seg_tens_o = seg_tens_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_m10_monitor.sv
`default_nettype none
//==============================================================================
// Module      : tb_counter_m10_monitor
// Description : Self-checking bench for counter_m10_monitor (ERR_W=4). The
//               reference keeps the tracked value as one number 0..99 and a
//               mode; every cycle the DUT outputs are compared with it, and
//               directed sequences pin key points with literal expectations.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_counter_m10_monitor;

    localparam int ERR_W = 4;
    localparam int CNT_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             d   = 1'b0;
    logic [3:0]       q   = 4'd0;
    logic             c   = 1'b0;
    logic [3:0]       ones, tens;
    logic             locked, err;
    logic [ERR_W-1:0] err_cnt;
`ifdef COUNTER_M10_MONITOR_SEG7_EN
    logic [6:0]       seg_ones, seg_tens;
    logic [6:0]       seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011,
                                       7'b1001111, 7'b1100110, 7'b1101101,
                                       7'b1111101, 7'b0000111, 7'b1111111,
                                       7'b1101111};
`endif

    counter_m10_monitor #(.ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .d_i       (d),
        .q_i       (q),
        .c_i       (c),
        .ones_o    (ones),
        .tens_o    (tens),
        .locked_o  (locked),
        .err_o     (err),
        .err_cnt_o (err_cnt)
`ifdef COUNTER_M10_MONITOR_SEG7_EN
        ,
        .seg_ones_o(seg_ones),
        .seg_tens_o(seg_tens)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Reference: value 0..99, mode 0=idle 1=track 2=resync.
    int m_val = 0, m_mode = 0, m_cnt = 0, m_exp = 0;
    bit m_dir = 0, m_err = 0, m_cexp = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_val = 0; m_mode = 0; m_dir = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_err = 0;
            if (en) begin
                if (m_mode == 1) begin
                    m_exp  = m_dir ? (m_val + 99) % 100 : (m_val + 1) % 100;
                    m_cexp = (int'(q) == 9 && !d) || (int'(q) == 0 && d);
                    if (int'(q) != m_exp % 10 || c != m_cexp) begin
                        m_err = 1; m_mode = 2;
                    end else begin
                        m_val = m_exp; m_dir = d;
                    end
                end else if (int'(q) <= 9) begin
                    m_val = (m_val / 10) * 10 + int'(q); m_dir = d; m_mode = 1;
                end else begin
                    m_err = 1;
                end
                if (m_err && m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ones",    ones,    m_val % 10);
            chk("cyc_tens",    tens,    m_val / 10);
            chk("cyc_locked",  locked,  m_mode == 1);
            chk("cyc_err",     err,     m_err);
            chk("cyc_err_cnt", err_cnt, m_cnt);
`ifdef COUNTER_M10_MONITOR_SEG7_EN
            chk("cyc_seg_ones", seg_ones, seg_tab[m_val % 10]);
            chk("cyc_seg_tens", seg_tens, seg_tab[m_val / 10]);
`endif
        end
    end

    task automatic step(input bit e, input int qv, input bit cv, input bit dv);
        en = e; q = qv[3:0]; c = cv; d = dv;
        @(negedge clk);
    endtask
    task automatic up(input int qv);   step(1, qv, qv == 9, 0); endtask
    task automatic down(input int qv); step(1, qv, qv == 0, 1); endtask
    task automatic do_reset();
        rst = 1; en = 1; q = 4'd7;       // en high to show reset overrides it
        @(negedge clk);
        rst = 0; en = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("reset_ones", ones, 0);
        chk("reset_tens", tens, 0);
        chk("reset_locked", locked, 0);
        chk("reset_cnt", err_cnt, 0);

        // Up count 0..9,0,1 with an idle gap.
        up(0);
        chk("up_locked_first", locked, 1);
        for (int i = 1; i < 12; i++) begin
            up(i % 10);
            if (i == 5) step(0, 13, 1, 1);
        end
        chk("up_final_ones", ones, 1);
        chk("up_final_tens", tens, 1);
        chk("up_final_cnt", err_cnt, 0);

        // Flip direction on a legal up step to 2, then count down twice through 0->9.
        step(1, 2, 0, 1);
        for (int i = 0; i < 13; i++) down((11 - i + 10) % 10);
        chk("down_final_ones", ones, 9);
        chk("down_final_tens", tens, 9);
        chk("down_final_cnt", err_cnt, 0);

        // Wrong digit in TRACK, then re-acquire.
        do_reset();
        up(3); up(4);
        up(7);
        chk("bad_digit_err", err, 1);
        chk("bad_digit_cnt", err_cnt, 1);
        chk("bad_digit_unlock", locked, 0);
        chk("bad_digit_ones_held", ones, 4);
        step(0, 0, 0, 0);
        chk("gap_err_low", err, 0);
        up(2);
        chk("resync_locked", locked, 1);
        chk("resync_ones", ones, 2);
        chk("resync_tens", tens, 0);

        // Missing carry at 9, then out-of-range digit in RESYNC.
        for (int i = 3; i < 9; i++) up(i);
        step(1, 9, 0, 0);
        chk("no_carry_cnt", err_cnt, 2);
        step(1, 15, 0, 0);
        chk("resync_bad_err", err, 1);
        chk("resync_bad_cnt", err_cnt, 3);
        chk("resync_bad_unlock", locked, 0);
        up(5);

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) step(1, 15, 0, 0);
        chk("sat_cnt", err_cnt, 15);
        chk("sat_err_still", err, 1);
        up(6); up(7);
        do_reset();
        chk("midtrack_rst_ones", ones, 0);
        chk("midtrack_rst_locked", locked, 0);
        chk("midtrack_rst_cnt", err_cnt, 0);
        step(1, 5, 0, 1);
        chk("post_rst_load", ones, 5);

        // Count up to 38 from reset, then idle gaps with garbage inputs.
        do_reset();
        for (int i = 0; i < 39; i++) up(i % 10);
        chk("to38_ones", ones, 8);
        chk("to38_tens", tens, 3);
`ifdef COUNTER_M10_MONITOR_SEG7_EN
        chk("seg_ones_8", seg_ones, 7'b1111111);
        chk("seg_tens_3", seg_tens, 7'b1001111);
`endif
        for (int i = 0; i < 3; i++) step(0, 14 - i, i[0], ~i[0]);
        chk("gap_ones_hold", ones, 8);
        chk("gap_tens_hold", tens, 3);
        up(9);
        chk("after_gap_ones", ones, 9);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_m10_monitor.md
COUNTER_M10_MONITOR -- requirements
Module: counter_m10_monitor

Interface
REQ-001 Parameter ERR_W, default 8: width of the saturating error counter; legal range 4..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  sample strobe; q/c/d are sampled only on edges where en=1.
REQ-005 d  input  1  direction of the observed mod-10 counter; 0=up, 1=down.
REQ-006 q  input  4  observed ones digit from the counter.
REQ-007 c  input  1  observed carry/borrow from the counter.
REQ-008 ones  output  4  tracked ones digit, registered.
REQ-009 tens  output  4  tracked tens digit (0..9), registered.
REQ-010 locked  output  1  high while state is TRACK.
REQ-011 err  output  1  one-cycle pulse per detected protocol violation.
REQ-012 err_cnt  output  ERR_W  saturating count of violations.

Function
REQ-013 Each en=1 edge is one sample; en=0 edges SHALL leave all state, ones, tens and err_cnt unchanged and drive err=0.
REQ-014 States: IDLE, TRACK, RESYNC; encoding free.
REQ-015 IDLE: on a sample with q<=9, load ones<=q, store prev_d<=d, go TRACK; q>9 -> err pulse, err_cnt++, stay IDLE.
REQ-016 TRACK: expected_q = prev_d ? (prev_q==0 ? 9 : prev_q-1) : (prev_q==9 ? 0 : prev_q+1), where prev_q is current ones.
REQ-017 Expected carry for a sample: c_exp = (q==9 && d==0) || (q==0 && d==1), evaluated on the sampled q and d.
REQ-018 TRACK violation = (q != expected_q) or (q>9) or (c != c_exp); violation -> err=1 next cycle, err_cnt++, go RESYNC, ones/tens unchanged.
REQ-019 TRACK, no violation: ones<=q, prev_d<=d; tens changes only on a wrap: prev_q==9, q==0, prev_d==0 -> tens+1 (9 wraps to 0); prev_q==0, q==9, prev_d==1 -> tens-1 (0 wraps to 9).
REQ-020 RESYNC: next sample with q<=9 loads ones<=q, prev_d<=d, goes TRACK, no check, tens held; q>9 -> another err, stay RESYNC.
REQ-021 Latency: all outputs registered; a sample at edge N is reflected in ones/tens/locked/err after edge N.
REQ-022 err_cnt saturates at 2^ERR_W-1 and never wraps; err still pulses at saturation.
REQ-023 Direction change: d toggling between samples SHALL be legal; the check uses prev_d (direction in force for the step), carry check uses current d.
REQ-024 tens holds 0..9 only; no tens carry-out beyond 99/00 wrap.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, ones=0, tens=0, prev_d=0, locked=0, err=0, err_cnt=0, overriding en.
REQ-026 rst asserted mid-TRACK or mid-RESYNC SHALL discard all tracking; first sample after release is an IDLE load.

Configuration
REQ-027 Macro COUNTER_M10_MONITOR_SEG7_EN: when defined, add outputs seg_ones[6:0] and seg_tens[6:0], active-high, order {g,f,e,d,c,b,a}, registered from ones/tens (same cycle as ones/tens update), reset to 7'b0111111 (digit 0).
REQ-028 Without COUNTER_M10_MONITOR_SEG7_EN the seg ports and decode logic SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset then 12 up-samples q=0,1..9,0,1 (c=1 at q=9) -> locked=1 after first, tens=1 after q 9->0, final ones=1, err_cnt=0.
REQ-030 From ones=1,tens=1, 12 down-samples q=0,9,8..0,9 (c=1 at q=0, d=1) -> tens 1->0 on 0->9, then 0->9 on second 0->9, err_cnt=0.
REQ-031 In TRACK at ones=4 up, sample q=7 -> err pulse one cycle, err_cnt=1, locked=0; next sample q=2 -> locked=1, ones=2, tens unchanged.
REQ-032 Up at q=9 with c=0 -> violation, err_cnt+1, RESYNC; q=15 in RESYNC -> second err, stay RESYNC.
REQ-033 ERR_W=4, inject 20 violations -> err_cnt holds 15; rst mid-TRACK -> all outputs 0, state IDLE next cycle.
REQ-034 With COUNTER_M10_MONITOR_SEG7_EN, ones=8,tens=3 -> seg_ones=7'b1111111, seg_tens=7'b1001111; en=0 gaps leave all outputs unchanged.
